// File: rtl/seg_execute_muldiv_unit_pkg.sv
// Shared constants for the EX-stage multiply/divide unit: funct codes,
// the R-type ALUOp class and the sequencer state encoding.
package seg_execute_muldiv_unit_pkg;

  localparam logic [3:0] ALUOP_RTYPE = 4'b0010;

  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MTHI  = 6'b010001;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_MTLO  = 6'b010011;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } state_e;

endpackage

// File: rtl/seg_execute_muldiv_datapath.sv
// Iterative shift-add multiplier / restoring divider on magnitudes, with the
// sign correction applied combinationally to the final iteration registers.
module seg_execute_muldiv_datapath #(
  parameter int NB_DATA = 32
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               start_i,
  input  logic               step_i,
  input  logic               is_div_i,
  input  logic               is_signed_i,
  input  logic [NB_DATA-1:0] rs_i,
  input  logic [NB_DATA-1:0] rt_i,
  output logic [NB_DATA-1:0] res_hi_o,
  output logic [NB_DATA-1:0] res_lo_o
);

  logic [NB_DATA-1:0]   acc_q, acc_d, q_q, q_d, b_q, b_d;
  logic                 is_div_q, is_div_d, neg_q, neg_d;
  logic                 rem_neg_q, rem_neg_d, div0_q, div0_d;
  logic [NB_DATA-1:0]   rs_mag, rt_mag;
  logic [NB_DATA:0]     mul_sum, div_shift, div_diff;
  logic                 div_ge;
  logic [2*NB_DATA-1:0] prod, prod_fix;

  assign rs_mag = (is_signed_i && rs_i[NB_DATA-1]) ? -rs_i : rs_i;
  assign rt_mag = (is_signed_i && rt_i[NB_DATA-1]) ? -rt_i : rt_i;

  // Multiply: {acc,q} shifts right with the multiplier consumed from q[0].
  // Divide: {acc,q} shifts left, dividend bits enter acc from q's MSB.
  assign mul_sum   = {1'b0, acc_q} + (q_q[0] ? {1'b0, b_q} : '0);
  assign div_shift = {acc_q, q_q[NB_DATA-1]};
  assign div_ge    = div_shift >= {1'b0, b_q};
  assign div_diff  = div_shift - {1'b0, b_q};

  always_comb begin
    acc_d     = acc_q;
    q_d       = q_q;
    b_d       = b_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    div0_d    = div0_q;
    if (start_i) begin
      acc_d     = '0;
      q_d       = rs_mag;
      b_d       = rt_mag;
      is_div_d  = is_div_i;
      neg_d     = is_signed_i && (rs_i[NB_DATA-1] ^ rt_i[NB_DATA-1]);
      rem_neg_d = is_signed_i && rs_i[NB_DATA-1];
      div0_d    = (rt_i == '0);
    end else if (step_i) begin
      if (is_div_q) begin
        acc_d = div_ge ? div_diff[NB_DATA-1:0] : div_shift[NB_DATA-1:0];
        q_d   = {q_q[NB_DATA-2:0], div_ge};
      end else begin
        acc_d = mul_sum[NB_DATA:1];
        q_d   = {mul_sum[0], q_q[NB_DATA-1:1]};
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      acc_q     <= '0;
      q_q       <= '0;
      b_q       <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      div0_q    <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      q_q       <= q_d;
      b_q       <= b_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      div0_q    <= div0_d;
    end
  end

  // On divide-by-zero acc ends holding |rs|; re-applying the dividend sign
  // yields the raw rs, so only the quotient needs an override.
  assign prod     = {acc_q, q_q};
  assign prod_fix = neg_q ? -prod : prod;

  always_comb begin
    if (is_div_q) begin
      res_lo_o = div0_q ? '1 : (neg_q ? -q_q : q_q);
      res_hi_o = rem_neg_q ? -acc_q : acc_q;
    end else begin
      res_lo_o = prod_fix[NB_DATA-1:0];
      res_hi_o = prod_fix[2*NB_DATA-1:NB_DATA];
    end
  end

endmodule

// File: rtl/seg_execute_muldiv_unit.sv
// EX-stage HI/LO unit: decodes mul/div/move funct codes, sequences the
// multi-cycle datapath and stalls only HI/LO-dependent instructions.
module seg_execute_muldiv_unit
  import seg_execute_muldiv_unit_pkg::*;
#(
  parameter int NB_DATA = 32,
  parameter int NB_OP   = 4,
  parameter int NB_FUNC = 6,
  parameter int NB_CNT  = 6
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_valid,
  input  logic [NB_OP-1:0]   i_ALUOp,
  input  logic [NB_FUNC-1:0] i_funct,
  input  logic [NB_DATA-1:0] i_rs_data,
  input  logic [NB_DATA-1:0] i_rt_data,
  input  logic               i_flush,
  output logic               o_stall,
  output logic               o_busy,
  output logic [NB_DATA-1:0] o_hilo_rd_data,
  output logic               o_hilo_rd_valid,
  output logic [NB_DATA-1:0] o_hi,
  output logic [NB_DATA-1:0] o_lo
);

  state_e             state_q, state_d;
  logic               busy_q;
  logic [NB_CNT-1:0]  cnt_q;
  logic [NB_DATA-1:0] hi_q, lo_q, res_hi, res_lo;
  logic               hilo_op, is_muldiv, is_mf, is_mt;
  logic               dp_start, dp_step, fix_wr, mt_wr;

  // funct[1] selects LO / divide, funct[0] selects MT / unsigned.
  always_comb begin
    hilo_op   = 1'b0;
    is_muldiv = 1'b0;
    is_mf     = 1'b0;
    is_mt     = 1'b0;
    if (i_valid && (i_ALUOp == NB_OP'(ALUOP_RTYPE))) begin
      case (i_funct)
        NB_FUNC'(FN_MFHI), NB_FUNC'(FN_MFLO): begin hilo_op = 1'b1; is_mf = 1'b1; end
        NB_FUNC'(FN_MTHI), NB_FUNC'(FN_MTLO): begin hilo_op = 1'b1; is_mt = 1'b1; end
        NB_FUNC'(FN_MULT), NB_FUNC'(FN_MULTU),
        NB_FUNC'(FN_DIV),  NB_FUNC'(FN_DIVU): begin hilo_op = 1'b1; is_muldiv = 1'b1; end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != ST_IDLE);
      if (i_flush)       cnt_q <= '0;
      else if (dp_start) cnt_q <= NB_CNT'(NB_DATA);
      else if (dp_step)  cnt_q <= cnt_q - NB_CNT'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    if (i_flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (is_muldiv) state_d = ST_RUN;
        ST_RUN:  if (cnt_q == NB_CNT'(1)) state_d = ST_FIX;
        ST_FIX:  state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    dp_start = (state_q == ST_IDLE) && is_muldiv && !i_flush;
    dp_step  = (state_q == ST_RUN) && !i_flush;
    fix_wr   = (state_q == ST_FIX) && !i_flush;
  end

  seg_execute_muldiv_datapath #(.NB_DATA(NB_DATA)) u_datapath (
    .clk_i       (i_clk),
    .rst_n_i     (i_rst_n),
    .start_i     (dp_start),
    .step_i      (dp_step),
    .is_div_i    (i_funct[1]),
    .is_signed_i (!i_funct[0]),
    .rs_i        (i_rs_data),
    .rt_i        (i_rt_data),
    .res_hi_o    (res_hi),
    .res_lo_o    (res_lo)
  );

  assign mt_wr = is_mt && !busy_q && !i_flush;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (fix_wr) begin
      hi_q <= res_hi;
      lo_q <= res_lo;
    end else if (mt_wr) begin
      if (i_funct[1]) lo_q <= i_rs_data;
      else            hi_q <= i_rs_data;
    end
  end

  assign o_stall         = busy_q && hilo_op;
  assign o_busy          = busy_q;
  assign o_hilo_rd_valid = is_mf && !busy_q;
  assign o_hilo_rd_data  = o_hilo_rd_valid ? (i_funct[1] ? lo_q : hi_q) : '0;
  assign o_hi            = hi_q;
  assign o_lo            = lo_q;

endmodule

// File: tb/tb_seg_execute_muldiv_unit.sv
// Randomized self-checking bench for seg_execute_muldiv_unit against an
// arithmetic reference model of HI/LO.
module tb_seg_execute_muldiv_unit;

  localparam logic [5:0] F_MFHI = 6'b010000, F_MTHI = 6'b010001;
  localparam logic [5:0] F_MFLO = 6'b010010, F_MTLO = 6'b010011;
  localparam logic [5:0] F_MULT = 6'b011000, F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV  = 6'b011010, F_DIVU = 6'b011011;
  localparam logic [5:0] F_ADDU = 6'b100001;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b0;
  logic [3:0]  aluop = 4'b0;
  logic [5:0]  funct = 6'b0;
  logic [31:0] rs = 32'b0, rt = 32'b0;
  logic        flush = 1'b0;
  logic        stall, busy, rd_valid;
  logic [31:0] rd_data, hi, lo;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] hi_m = 32'b0, lo_m = 32'b0;

  always #5 clk = ~clk;

  seg_execute_muldiv_unit dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_ALUOp(aluop),
    .i_funct(funct), .i_rs_data(rs), .i_rt_data(rt), .i_flush(flush),
    .o_stall(stall), .o_busy(busy), .o_hilo_rd_data(rd_data),
    .o_hilo_rd_valid(rd_valid), .o_hi(hi), .o_lo(lo)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Returns {HI, LO} for a mul/div op, straight from the arithmetic rules.
  function automatic logic [63:0] model(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
    int sa, sb, sq, sr;
    longint sp;
    logic [63:0] ua, ub;
    sa = a; sb = b; ua = {32'b0, a}; ub = {32'b0, b};
    case (fn)
      F_MULT:  begin sp = longint'(sa) * longint'(sb); return sp; end
      F_MULTU: return ua * ub;
      F_DIV: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        sq = sa / sb; sr = sa % sb;
        return {sr, sq};
      end
      default: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  task automatic drive(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
    valid = 1'b1; aluop = 4'b0010; funct = fn; rs = a; rt = b;
  endtask

  task automatic idle();
    valid = 1'b0; aluop = 4'b0; funct = 6'b0;
  endtask

  // Issues one mul/div, times o_busy, pokes an independent ADDU mid-flight.
  task automatic run_muldiv(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
    int busy_cnt;
    logic [63:0] exp;
    exp = model(fn, a, b);
    @(negedge clk); drive(fn, a, b);
    @(negedge clk); idle();
    busy_cnt = 0;
    for (int c = 0; c < 100 && busy; c++) begin
      busy_cnt++;
      if (busy_cnt == 5) begin
        drive(F_ADDU, 32'h1, 32'h2); #1;
        check_val("addu_no_stall", 64'(stall), 64'd0);
      end
      @(negedge clk); idle();
    end
    hi_m = exp[63:32]; lo_m = exp[31:0];
    check_val("busy_cycles", 64'(busy_cnt), 64'd33);
    check_val("hi", 64'(hi), 64'(hi_m));
    check_val("lo", 64'(lo), 64'(lo_m));
    drive(F_MFHI, 32'h0, 32'h0); #1;
    check_val("mfhi_valid", 64'(rd_valid), 64'd1);
    check_val("mfhi_data", 64'(rd_data), 64'(hi_m));
    drive(F_MFLO, 32'h0, 32'h0); #1;
    check_val("mflo_data", 64'(rd_data), 64'(lo_m));
    idle();
    $display("op funct=%b rs=%h rt=%h -> hi=%h lo=%h busy=%0d", fn, a, b, hi, lo, busy_cnt);
  endtask

  initial begin : main
    int stall_cnt;
    logic [5:0]  fn;
    logic [31:0] a, b;
    logic [63:0] exp;

    #12;
    check_val("rst_hi", 64'(hi), 64'd0);
    check_val("rst_lo", 64'(lo), 64'd0);
    check_val("rst_busy", 64'(busy), 64'd0);
    check_val("rst_stall", 64'(stall), 64'd0);
    check_val("rst_rd_valid", 64'(rd_valid), 64'd0);
    check_val("rst_rd_data", 64'(rd_data), 64'd0);
    @(negedge clk); rst_n = 1'b1;

    run_muldiv(F_MULTU, 32'hFFFF_FFFF, 32'h2);
    check_val("multu_max_hi", 64'(hi), 64'h1);
    check_val("multu_max_lo", 64'(lo), 64'hFFFF_FFFE);
    run_muldiv(F_MULT, -32'sd3, 32'd7);
    run_muldiv(F_DIV, -32'sd7, 32'd2);
    check_val("div_neg_lo", 64'(lo), 64'hFFFF_FFFD);
    check_val("div_neg_hi", 64'(hi), 64'hFFFF_FFFF);
    run_muldiv(F_DIVU, 32'h1234, 32'h0);
    run_muldiv(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    run_muldiv(F_DIV, -32'sd5, 32'h0);
    run_muldiv(F_DIV, 32'h8000_0000, 32'd3);

    for (int i = 0; i < 24; i++) begin
      fn = F_MULT + 6'($urandom_range(0, 3));
      a = $urandom; b = $urandom;
      if ($urandom_range(0, 7) == 0) b = 32'h0;
      else if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 255));
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
      run_muldiv(fn, a, b);
    end

    // Dependent MFLO right behind a MULT stalls until the result lands.
    a = $urandom; b = $urandom;
    exp = model(F_MULT, a, b);
    @(negedge clk); drive(F_MULT, a, b);
    @(negedge clk); drive(F_MFLO, 32'h0, 32'h0);
    stall_cnt = 0;
    for (int c = 0; c < 100 && stall; c++) begin
      stall_cnt++;
      @(negedge clk);
    end
    hi_m = exp[63:32]; lo_m = exp[31:0];
    check_val("mflo_stall_cycles", 64'(stall_cnt), 64'd33);
    check_val("mflo_after_stall_valid", 64'(rd_valid), 64'd1);
    check_val("mflo_after_stall_data", 64'(rd_data), 64'(lo_m));
    idle();
    $display("op stalled mflo after mult rs=%h rt=%h -> lo=%h stall=%0d", a, b, rd_data, stall_cnt);

    // Flush mid-divide keeps the previously written HI/LO.
    @(negedge clk); drive(F_MTHI, 32'hA5A5_A5A5, 32'h0);
    @(negedge clk); drive(F_MTLO, 32'h3C3C_0F0F, 32'h0);
    @(negedge clk); idle();
    hi_m = 32'hA5A5_A5A5; lo_m = 32'h3C3C_0F0F;
    check_val("mthi", 64'(hi), 64'(hi_m));
    check_val("mtlo", 64'(lo), 64'(lo_m));
    drive(F_DIV, 32'd1000, 32'd7);
    @(negedge clk); idle();
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    check_val("flush_busy", 64'(busy), 64'd0);
    repeat (40) @(negedge clk);
    check_val("flush_hi", 64'(hi), 64'(hi_m));
    check_val("flush_lo", 64'(lo), 64'(lo_m));
    $display("op div flushed at cycle 10 -> hi=%h lo=%h", hi, lo);

    drive(F_DIVU, 32'd50, 32'd5); flush = 1'b1;
    @(negedge clk); flush = 1'b0; idle();
    check_val("flush_wins_busy", 64'(busy), 64'd0);
    $display("op divu with flush -> busy=%0d", busy);

    // Asynchronous reset in the middle of a multiply.
    drive(F_MULT, 32'd5, 32'd6);
    @(negedge clk); idle();
    repeat (4) @(negedge clk);
    rst_n = 1'b0; #1;
    check_val("midrst_hi", 64'(hi), 64'd0);
    check_val("midrst_lo", 64'(lo), 64'd0);
    check_val("midrst_busy", 64'(busy), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    hi_m = 32'h0;
    drive(F_MTLO, 32'h55, 32'h0);
    @(negedge clk); idle();
    check_val("mtlo_after_rst", 64'(lo), 64'h55);
    check_val("hi_after_rst", 64'(hi), 64'(hi_m));
    repeat (40) @(negedge clk);
    check_val("no_spurious_write_lo", 64'(lo), 64'h55);
    $display("op reset mid-mult then mtlo -> hi=%h lo=%h", hi, lo);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
